tile_cfg_ctrl: RTL and testbench
================================

Name: tile_cfg_ctrl

Overview:
- Runtime configuration controller for the accelerator's dynamically sizable per-tile parameters (CQ slice size, TQ limits, GVT period, logging/stats masks).
- Host writes go through the OCL slave into staged registers. A COMMIT write quiesces the selected tiles, pushes only the changed registers to them over a broadcast config bus, collects per-tile acks, then releases the tiles.
- Sits between the OCL slave of tile 0 and all tiles.
- Generalises the compile-time config into N_CFG_REGS runtime registers with a per-tile target mask, an epoch counter and a drain timeout.

Parameters:
- N_TILES, 8, number of tiles; one quiesce/idle/ack bit each.
- N_CFG_REGS, 16, number of staged config registers (power of two).
- CFG_WIDTH, 32, register and data width.
- REG_ADDR_W, $clog2(N_CFG_REGS)+2, host address width.
- TIMEOUT_W, 16, width of the drain timeout counter.
- EPOCH_W, 8, width of the config epoch counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- reg_wvalid  in  1  host write request
- reg_wready  out  1  write accepted this cycle
- reg_waddr  in  REG_ADDR_W  write address
- reg_wdata  in  CFG_WIDTH  write data
- reg_raddr  in  REG_ADDR_W  read address
- reg_rdata  out  CFG_WIDTH  read data, 1-cycle latency
- quiesce_req  out  N_TILES  per-tile stop-dispatch request
- tile_idle  in  N_TILES  tile drained (no in-flight tasks)
- cfg_valid  out  1  config beat valid
- cfg_addr  out  $clog2(N_CFG_REGS)  register index
- cfg_data  out  CFG_WIDTH  register value
- cfg_tile_mask  out  N_TILES  tiles targeted by this beat
- cfg_ack  in  N_TILES  per-tile single-cycle beat ack
- busy  out  1  commit in progress
- cfg_epoch  out  EPOCH_W  count of successful commits

Behaviour:
- Address map:
  - 0..N_CFG_REGS-1: staged regs.
  - N_CFG_REGS: TILE_MASK (low N_TILES bits).
  - N_CFG_REGS+1: COMMIT (write-only; data ignored).
  - N_CFG_REGS+2: STATUS (read: bit0 busy, bit1 sticky timeout error, [15:8] epoch). Writing 1 to bit1 clears the error.
  - Other addresses: writes accepted and dropped; reads return 0.
- reg_wready = !busy, except STATUS writes, which are always accepted. A staged write sets that register's dirty bit.
- Reset (async): staged regs 0, dirty 0, TILE_MASK all ones, error 0, epoch 0. Outputs: quiesce_req 0, cfg_valid 0, busy 0, reg_rdata 0.
- Reset mid-commit aborts immediately. Tiles must treat quiesce_req falling as resume.
- FSM states: IDLE, DRAIN, PUSH, WAIT_ACK, RELEASE.
  - IDLE: a COMMIT write latches mask_q = TILE_MASK.
    - If mask_q == 0 or no dirty bits: go to RELEASE the next cycle. Epoch still increments.
    - Otherwise: go to DRAIN, set busy=1, quiesce_req = mask_q, and clear the timeout counter.
  - DRAIN: when (tile_idle & mask_q) == mask_q, go to PUSH.
    - The counter increments each cycle. On reaching all ones: set the error bit, drop quiesce_req, go to IDLE. No push happens, epoch is unchanged, and dirty bits are kept.
  - PUSH: a priority encoder selects the lowest dirty index.
    - Drive cfg_valid=1, cfg_addr, cfg_data, cfg_tile_mask = mask_q.
    - Clear ack_seen; go to WAIT_ACK. cfg_valid rises the cycle after PUSH entry.
  - WAIT_ACK: hold the beat. ack_seen |= cfg_ack & mask_q.
    - When (ack_seen | (cfg_ack & mask_q)) == mask_q: drop cfg_valid and clear that dirty bit.
    - Then go to PUSH if any dirty bit remains, else to RELEASE.
    - Acks from unmasked tiles are ignored. Duplicate acks are harmless.
  - RELEASE: quiesce_req=0, epoch+1 (wraps mod 2^EPOCH_W), busy=0, go to IDLE.
- Commit latency with K dirty regs and zero ack delay: 1 (DRAIN check) + 2K + 1 cycles from the COMMIT accept.
- Simultaneous events:
  - A STATUS error-clear in the same cycle as a timeout leaves the error set.
  - A COMMIT write while busy is not accepted (wready=0).

Decomposition:
- Shared package holds:
  - the address offsets CFG_MASK_ADDR, CFG_COMMIT_ADDR, CFG_STATUS_ADDR;
  - a cfg_beat_t struct (addr, data, mask);
  - the enum cfg_state_t;
  - named indices of the config registers (e.g. CFG_LOG_CQ_SIZE).
- One natural sub-module: lowest_set_idx (a parametrised priority encoder over the dirty vector).

Test Plan:
- Write reg3=0x40 and reg7=0x5, then COMMIT with the default mask; idle held high and acks after 2 cycles.
  -> Two beats: (3,0x40) then (7,0x5), mask 0xFF. Epoch 0->1, busy low afterwards, quiesce_req pulses 0xFF.
- TILE_MASK=0x05; tile 2 acks 3 cycles late and tile 5 acks spuriously.
  -> cfg_valid is held until tile 2 acks; tile 5's ack has no effect; dirty is cleared after the tile 2 ack.
- COMMIT with tile 4 never idle, TIMEOUT_W=4.
  -> After 15 DRAIN cycles: error=1, quiesce_req=0, no cfg_valid, epoch unchanged, reg still dirty. Clearing via STATUS then a re-commit succeeds.
- COMMIT with no dirty regs.
  -> No quiesce or beats; busy for 1 cycle; epoch+1.
- Staged or COMMIT write while busy.
  -> reg_wready=0 and the value is unchanged. STATUS read during the commit returns bit0=1.
- Assert rst during WAIT_ACK.
  -> All outputs 0 in the same cycle, epoch 0, TILE_MASK reads back 0xFF.

Source files
------------

// File: rtl/tile_cfg_ctrl_pkg.sv
// tile_cfg_ctrl_pkg: shared address offsets, beat type, FSM states and config register names
package tile_cfg_ctrl_pkg;

    // Control registers sit directly above the staged block; add N_CFG_REGS to get the address
    localparam int CFG_MASK_ADDR   = 0;
    localparam int CFG_COMMIT_ADDR = 1;
    localparam int CFG_STATUS_ADDR = 2;

    // Named staged-register indices
    localparam int CFG_LOG_CQ_SIZE = 0;
    localparam int CFG_TQ_LIMIT    = 1;
    localparam int CFG_TQ_SPILL    = 2;
    localparam int CFG_GVT_PERIOD  = 3;
    localparam int CFG_LOG_MASK    = 4;
    localparam int CFG_STATS_MASK  = 5;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [7:0]  mask;
    } cfg_beat_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH,
        ST_WAIT_ACK,
        ST_RELEASE
    } cfg_state_t;

endpackage

// File: rtl/lowest_set_idx.sv
// lowest_set_idx: priority encoder returning the index of the lowest set bit
//   vec : input vector
//   idx : index of lowest set bit (0 when vec is empty)
//   any : vec has at least one bit set
module lowest_set_idx #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) idx = W'(i);
        any = |vec;
    end
endmodule

// File: rtl/tile_cfg_ctrl.sv
// tile_cfg_ctrl: runtime per-tile config controller (stage, quiesce, push changed regs, collect acks)
//   host : reg_wvalid/wready/waddr/wdata write port, reg_raddr -> reg_rdata with 1-cycle latency
//   tile : quiesce_req / tile_idle drain handshake; cfg_valid/addr/data/tile_mask beat; cfg_ack per tile
//   stat : busy while a commit runs; cfg_epoch counts successful commits
module tile_cfg_ctrl #(
    parameter int N_TILES    = 8,
    parameter int N_CFG_REGS = 16,
    parameter int CFG_WIDTH  = 32,
    parameter int REG_ADDR_W = $clog2(N_CFG_REGS) + 2,
    parameter int TIMEOUT_W  = 16,
    parameter int EPOCH_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reg_wvalid,
    output logic                          reg_wready,
    input  logic [REG_ADDR_W-1:0]         reg_waddr,
    input  logic [CFG_WIDTH-1:0]          reg_wdata,
    input  logic [REG_ADDR_W-1:0]         reg_raddr,
    output logic [CFG_WIDTH-1:0]          reg_rdata,
    output logic [N_TILES-1:0]            quiesce_req,
    input  logic [N_TILES-1:0]            tile_idle,
    output logic                          cfg_valid,
    output logic [$clog2(N_CFG_REGS)-1:0] cfg_addr,
    output logic [CFG_WIDTH-1:0]          cfg_data,
    output logic [N_TILES-1:0]            cfg_tile_mask,
    input  logic [N_TILES-1:0]            cfg_ack,
    output logic                          busy,
    output logic [EPOCH_W-1:0]            cfg_epoch
);
    import tile_cfg_ctrl_pkg::*;

    localparam int IDX_W = $clog2(N_CFG_REGS);
    localparam logic [REG_ADDR_W-1:0] A_MASK   = REG_ADDR_W'(N_CFG_REGS + CFG_MASK_ADDR);
    localparam logic [REG_ADDR_W-1:0] A_COMMIT = REG_ADDR_W'(N_CFG_REGS + CFG_COMMIT_ADDR);
    localparam logic [REG_ADDR_W-1:0] A_STATUS = REG_ADDR_W'(N_CFG_REGS + CFG_STATUS_ADDR);

    cfg_state_t             state_q, state_d;
    logic [CFG_WIDTH-1:0]   regs_q [N_CFG_REGS];
    logic [CFG_WIDTH-1:0]   regs_d [N_CFG_REGS];
    logic [N_CFG_REGS-1:0]  dirty_q, dirty_d;
    logic [N_TILES-1:0]     tmask_q, tmask_d;
    logic [N_TILES-1:0]     mask_q, mask_d;
    logic [N_TILES-1:0]     quiesce_q, quiesce_d;
    logic [N_TILES-1:0]     ack_seen_q, ack_seen_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [EPOCH_W-1:0]     epoch_q, epoch_d;
    logic [IDX_W-1:0]       addr_q, addr_d;
    logic [CFG_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       low_idx;
    logic                   dirty_any;
    logic                   wr;

    lowest_set_idx #(.N(N_CFG_REGS)) u_enc (.vec(dirty_q), .idx(low_idx), .any(dirty_any));

    assign busy          = state_q != ST_IDLE;
    assign reg_wready    = !busy || reg_waddr == A_STATUS;
    assign wr            = reg_wvalid && reg_wready;
    assign cfg_valid     = state_q == ST_WAIT_ACK;
    assign cfg_addr      = addr_q;
    assign cfg_data      = regs_q[addr_q];
    assign cfg_tile_mask = mask_q;
    assign quiesce_req   = quiesce_q;
    assign cfg_epoch     = epoch_q;
    assign reg_rdata     = rdata_q;

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        dirty_d    = dirty_q;
        tmask_d    = tmask_q;
        mask_d     = mask_q;
        quiesce_d  = quiesce_q;
        ack_seen_d = ack_seen_q;
        cnt_d      = cnt_q;
        epoch_d    = epoch_q;
        addr_d     = addr_q;
        err_d      = err_q;
        if (wr && reg_waddr < A_MASK) begin
            regs_d[reg_waddr[IDX_W-1:0]]  = reg_wdata;
            dirty_d[reg_waddr[IDX_W-1:0]] = 1'b1;
        end
        if (wr && reg_waddr == A_MASK) tmask_d = reg_wdata[N_TILES-1:0];
        // a timeout below overrides a same-cycle clear, so the error stays set
        if (wr && reg_waddr == A_STATUS && reg_wdata[1]) err_d = 1'b0;
        case (state_q)
            ST_IDLE: if (wr && reg_waddr == A_COMMIT) begin
                mask_d    = tmask_q;
                cnt_d     = '0;
                state_d   = (tmask_q == '0 || !dirty_any) ? ST_RELEASE : ST_DRAIN;
                quiesce_d = state_d == ST_DRAIN ? tmask_q : '0;
            end
            ST_DRAIN: if ((tile_idle & mask_q) == mask_q) state_d = ST_PUSH;
            else begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (&cnt_d) begin
                    err_d     = 1'b1;
                    quiesce_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_PUSH: begin
                addr_d     = low_idx;
                ack_seen_d = '0;
                state_d    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                ack_seen_d = ack_seen_q | (cfg_ack & mask_q);
                if (ack_seen_d == mask_q) begin
                    dirty_d[addr_q] = 1'b0;
                    state_d         = |dirty_d ? ST_PUSH : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                quiesce_d = '0;
                epoch_d   = epoch_q + EPOCH_W'(1);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (reg_raddr < A_MASK) rdata_d = regs_q[reg_raddr[IDX_W-1:0]];
        else if (reg_raddr == A_MASK) rdata_d = CFG_WIDTH'(tmask_q);
        else if (reg_raddr == A_STATUS) begin
            rdata_d[0]           = busy;
            rdata_d[1]           = err_q;
            rdata_d[8 +: EPOCH_W] = epoch_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            regs_q     <= '{default: '0};
            dirty_q    <= '0;
            tmask_q    <= '1;
            mask_q     <= '0;
            quiesce_q  <= '0;
            ack_seen_q <= '0;
            cnt_q      <= '0;
            epoch_q    <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            regs_q     <= regs_d;
            dirty_q    <= dirty_d;
            tmask_q    <= tmask_d;
            mask_q     <= mask_d;
            quiesce_q  <= quiesce_d;
            ack_seen_q <= ack_seen_d;
            cnt_q      <= cnt_d;
            epoch_q    <= epoch_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_tile_cfg_ctrl.sv
// tb_tile_cfg_ctrl: directed bench with a commit-level scoreboard for tile_cfg_ctrl
module tb_tile_cfg_ctrl;
    localparam int TW = 4;
    localparam int A_MASK = 16, A_COMMIT = 17, A_STATUS = 18;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
        logic [7:0]  m;
    } beat_t;

    logic        clk = 0, rst = 0;
    logic        reg_wvalid = 0, reg_wready;
    logic [5:0]  reg_waddr = 0, reg_raddr = 0;
    logic [31:0] reg_wdata = 0, reg_rdata;
    logic [7:0]  quiesce_req, tile_idle = 8'hFF, cfg_tile_mask, cfg_ack = 0, cfg_epoch;
    logic        cfg_valid, busy;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;

    tile_cfg_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .reg_wvalid(reg_wvalid), .reg_wready(reg_wready),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .quiesce_req(quiesce_req), .tile_idle(tile_idle), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_tile_mask(cfg_tile_mask), .cfg_ack(cfg_ack), .busy(busy),
        .cfg_epoch(cfg_epoch)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // specification-level model
    logic [31:0] m_regs [16];
    logic [15:0] m_dirty;
    logic [7:0]  m_tmask, m_qmask, m_epoch;
    logic        m_err;
    beat_t       exp_q[$], obs[$];
    int          exp_lat, busy_cnt, valid_cnt;
    logic [7:0]  q_seen, seen;
    bit          hold;
    // tile behaviour
    int          ack_dly [8];
    logic [7:0]  ack_en = 8'hFF, spur = 8'h00;
    int          vcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_dirty = 0; m_tmask = 8'hFF; m_qmask = 0; m_epoch = 0; m_err = 0;
        exp_q.delete(); seen = 0; hold = 0;
    endtask

    // tiles ack each beat a fixed number of cycles after cfg_valid is first seen
    always @(posedge clk) begin
        #1;
        if (cfg_valid) begin
            for (int t = 0; t < 8; t++) cfg_ack[t] = ack_en[t] && vcnt == ack_dly[t];
            cfg_ack = cfg_ack | spur;
            vcnt++;
        end else begin
            vcnt = 0;
            cfg_ack = 0;
        end
    end

    // per-cycle scoreboard
    always @(negedge clk) if (!rst) begin
        if (busy) busy_cnt++;
        q_seen = q_seen | quiesce_req;
        if (cfg_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
                chk("beat_addr", cfg_addr, exp_q[0].a);
                chk("beat_data", cfg_data, exp_q[0].d);
                chk("beat_mask", cfg_tile_mask, exp_q[0].m);
                chk("beat_quiesce", quiesce_req, exp_q[0].m);
                seen = seen | (cfg_ack & exp_q[0].m);
                if (seen == exp_q[0].m) begin
                    obs.push_back('{cfg_addr, cfg_data, cfg_tile_mask});
                    void'(exp_q.pop_front());
                    seen = 0;
                    hold = 0;
                end else hold = 1;
            end
        end else if (hold) begin
            chk("beat_held", 0, 1);
            hold = 0;
        end
        if (!busy) begin
            chk("idle_quiesce", quiesce_req, 0);
            chk("idle_epoch", cfg_epoch, m_epoch);
        end else chk("quiesce_sel", quiesce_req == 0 || quiesce_req == m_qmask, 1);
    end

    task automatic wr(input int a, input logic [31:0] d, input bit ok);
        @(posedge clk); #1;
        reg_wvalid = 1; reg_waddr = 6'(a); reg_wdata = d;
        @(negedge clk);
        chk($sformatf("wready_%0d", a), reg_wready, 32'(ok));
        @(posedge clk); #1;
        reg_wvalid = 0;
        if (ok) begin
            if (a < 16) begin m_regs[a] = d; m_dirty[a] = 1; end
            if (a == A_MASK) m_tmask = d[7:0];
            if (a == A_STATUS && d[1]) m_err = 0;
        end
    endtask

    task automatic rd_chk(input string nm, input int a, input logic [31:0] exp);
        @(posedge clk); #1;
        reg_raddr = 6'(a);
        @(posedge clk);
        @(negedge clk);
        chk(nm, reg_rdata, exp);
    endtask

    task automatic commit_start(input int dly);
        int k = 0;
        logic [7:0] mk = m_tmask;
        for (int i = 0; i < 16; i++) if (m_dirty[i]) k++;
        wr(A_COMMIT, 0, 1);
        busy_cnt = 0; valid_cnt = 0; q_seen = 0; seen = 0; hold = 0;
        obs.delete();
        if (mk == 0 || k == 0) begin
            m_qmask = 0; exp_lat = 1; m_epoch++;
        end else if ((tile_idle & mk) != mk) begin
            m_qmask = mk; exp_lat = 2**TW - 1; m_err = 1;
        end else begin
            m_qmask = mk;
            exp_lat = 2 + k * (2 + dly);
            for (int i = 0; i < 16; i++) if (m_dirty[i]) exp_q.push_back('{4'(i), m_regs[i], mk});
            m_dirty = 0;
            m_epoch++;
        end
    endtask

    task automatic commit_end(input string nm);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (busy && n < 300);
        chk({nm, "_done"}, busy, 0);
        chk({nm, "_lat"}, busy_cnt, exp_lat);
        chk({nm, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int t = 0; t < 8; t++) ack_dly[t] = 0;
        model_reset();
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_valid", cfg_valid, 0);
        chk("rst_quiesce", quiesce_req, 0);
        rd_chk("rst_tmask", A_MASK, 32'hFF);
        rd_chk("rst_status", A_STATUS, 0);
        rd_chk("rst_reg0", 0, 0);
        wr(20, 32'hDEAD, 1);
        rd_chk("unmapped_rd", 20, 0);
        rd_chk("commit_rd", A_COMMIT, 0);

        // two beats, default mask, acks two cycles late
        for (int t = 0; t < 8; t++) ack_dly[t] = 2;
        wr(3, 32'h40, 1);
        wr(7, 32'h5, 1);
        rd_chk("t1_reg3", 3, 32'h40);
        commit_start(2);
        commit_end("t1");
        chk("t1_lat_lit", busy_cnt, 10);
        chk("t1_valid_cycles", valid_cnt, 6);
        chk("t1_quiesce", q_seen, 8'hFF);
        chk("t1_epoch", cfg_epoch, 1);
        chk("t1_nbeats", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("t1_beat0", obs[0], {4'd3, 32'h40, 8'hFF});
            chk("t1_beat1", obs[1], {4'd7, 32'h5, 8'hFF});
        end

        // mask 0x05, tile 2 late, tile 5 spurious
        for (int t = 0; t < 8; t++) ack_dly[t] = 0;
        ack_dly[2] = 3;
        spur = 8'h20;
        wr(A_MASK, 32'h05, 1);
        wr(1, 32'h1234, 1);
        commit_start(3);
        commit_end("t2");
        chk("t2_lat_lit", busy_cnt, 7);
        chk("t2_valid_cycles", valid_cnt, 4);
        chk("t2_quiesce", q_seen, 8'h05);
        chk("t2_epoch", cfg_epoch, 2);
        if (obs.size() >= 1) chk("t2_beat0", obs[0], {4'd1, 32'h1234, 8'h05});
        else chk("t2_nbeats", obs.size(), 1);
        spur = 0;
        ack_dly[2] = 0;
        wr(A_MASK, 32'hFF, 1);

        // drain timeout with tile 4 busy
        wr(2, 32'hAB, 1);
        tile_idle = 8'hEF;
        commit_start(0);
        commit_end("t3");
        chk("t3_lat_lit", busy_cnt, 15);
        chk("t3_valid_cycles", valid_cnt, 0);
        chk("t3_quiesce", q_seen, 8'hFF);
        chk("t3_epoch", cfg_epoch, 2);
        rd_chk("t3_status_err", A_STATUS, 32'h0202);
        wr(A_STATUS, 32'h2, 1);
        rd_chk("t3_status_clr", A_STATUS, 32'h0200);
        tile_idle = 8'hFF;
        commit_start(0);
        commit_end("t3r");
        chk("t3r_lat_lit", busy_cnt, 4);
        chk("t3r_epoch", cfg_epoch, 3);
        if (obs.size() >= 1) chk("t3r_beat0", obs[0], {4'd2, 32'hAB, 8'hFF});
        else chk("t3r_nbeats", obs.size(), 1);

        // nothing dirty
        commit_start(0);
        commit_end("t4");
        chk("t4_lat_lit", busy_cnt, 1);
        chk("t4_quiesce", q_seen, 0);
        chk("t4_valid_cycles", valid_cnt, 0);
        chk("t4_epoch", cfg_epoch, 4);

        // writes while busy are refused
        for (int t = 0; t < 8; t++) ack_dly[t] = 6;
        wr(9, 32'h99, 1);
        commit_start(6);
        wr(9, 32'h1111, 0);
        wr(A_COMMIT, 0, 0);
        rd_chk("t5_status_busy", A_STATUS, 32'h0401);
        commit_end("t5");
        chk("t5_lat_lit", busy_cnt, 10);
        rd_chk("t5_reg9", 9, 32'h99);
        commit_start(0);
        commit_end("t5e");
        chk("t5e_lat_lit", busy_cnt, 1);
        chk("t5e_epoch", cfg_epoch, 6);

        // reset while waiting for acks
        ack_en = 0;
        wr(4, 32'h77, 1);
        commit_start(0);
        for (int i = 0; i < 50 && !cfg_valid; i++) @(negedge clk);
        chk("t6_in_wait", cfg_valid, 1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("t6_valid", cfg_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_quiesce", quiesce_req, 0);
        chk("t6_epoch", cfg_epoch, 0);
        chk("t6_rdata", reg_rdata, 0);
        chk("t6_beat", {cfg_addr, cfg_data, cfg_tile_mask}, 0);
        model_reset();
        ack_en = 8'hFF;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        rd_chk("t6_tmask", A_MASK, 32'hFF);
        rd_chk("t6_reg4", 4, 0);
        rd_chk("t6_status", A_STATUS, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
